ptp_frame_fifo: RTL



---
 rtl/ptp_fifo_pkg.sv | 32 +++
 rtl/ptp_fifo_ram.sv | 22 ++
 rtl/ptp_frame_fifo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ptp_fifo_pkg.sv
// Shared types and helpers for the PTP frame FIFO: pointer sizing, modular
// pointer difference, frame-operation encoding and the registered status bundle.
package ptp_fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

  // Occupancy between two pointers that wrap modulo 2**pw.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (a - b) & mask;
  endfunction

  typedef enum logic [1:0] {
    FRAME_HOLD,
    FRAME_COMMIT,
    FRAME_DROP
  } frame_op_t;

  typedef struct packed {
    logic rdempty;
    logic full;
    logic almost_full;
    logic drop;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/ptp_fifo_ram.sv
// Simple dual-port RAM, WIDTH x 2**DEPTH_LOG2, registered read port, no array reset.
module ptp_fifo_ram #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ptp_frame_fifo.sv
// Frame-aware FIFO: speculative writes published by commit or rolled back by discard.
// Optional show-ahead read mode selected by PTP_FIFO_SHOWAHEAD_EN.
module ptp_frame_fifo
  import ptp_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  commit,
  input  logic                  discard,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  rdempty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic [DEPTH_LOG2:0]   rdusedw,
  output logic                  drop,
  output logic                  underflow
);

  localparam int unsigned PW = ptr_width(DEPTH_LOG2);
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [PW-1:0]    wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0]    wr_nxt, cm_nxt, rd_nxt;
  logic [PW-1:0]    usedw_q, rdusedw_q, usedw_nxt, rdusedw_nxt;
  logic             poison, poison_nxt;
  fifo_flags_t      flags_q, flags_nxt;
  frame_op_t        op;
  logic             wr_acc, rd_acc, wr_lost;
  logic             q_zero, q_zero_nxt;
  logic             ram_re;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [WIDTH-1:0] ram_q;

  always_comb begin
    wr_acc  = wrreq & ~flags_q.full;
    wr_lost = wrreq & flags_q.full;
    rd_acc  = rdreq & ~flags_q.rdempty;

    // A word lost to a full FIFO in the commit cycle still poisons that frame.
    if (discard || (commit && (poison || wr_lost))) op = FRAME_DROP;
    else if (commit)                                op = FRAME_COMMIT;
    else                                            op = FRAME_HOLD;

    wr_nxt     = wr_ptr + PW'(wr_acc);
    cm_nxt     = cm_ptr;
    rd_nxt     = rd_ptr + PW'(rd_acc);
    poison_nxt = poison | wr_lost;
    unique case (op)
      FRAME_COMMIT: cm_nxt = wr_nxt;
      FRAME_DROP: begin
        wr_nxt     = cm_ptr;
        poison_nxt = 1'b0;
      end
      default: ;
    endcase

    usedw_nxt   = PW'(ptr_diff(32'(wr_nxt), 32'(rd_nxt), PW));
    rdusedw_nxt = PW'(ptr_diff(32'(cm_nxt), 32'(rd_nxt), PW));

    flags_nxt             = '0;
    flags_nxt.rdempty     = (rdusedw_nxt == '0);
    flags_nxt.full        = (usedw_nxt == DEPTH_P);
    flags_nxt.almost_full = (32'(usedw_nxt) >= AFULL_THRESH);
    flags_nxt.drop        = (op == FRAME_DROP);
    flags_nxt.underflow   = rdreq & flags_q.rdempty;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr            <= '0;
      cm_ptr            <= '0;
      rd_ptr            <= '0;
      poison            <= 1'b0;
      usedw_q           <= '0;
      rdusedw_q         <= '0;
      flags_q           <= '0;
      flags_q.rdempty   <= 1'b1;
      q_zero            <= 1'b1;
    end else begin
      wr_ptr    <= wr_nxt;
      cm_ptr    <= cm_nxt;
      rd_ptr    <= rd_nxt;
      poison    <= poison_nxt;
      usedw_q   <= usedw_nxt;
      rdusedw_q <= rdusedw_nxt;
      flags_q   <= flags_nxt;
      q_zero    <= q_zero_nxt;
    end
  end

  ptp_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

`ifdef PTP_FIFO_SHOWAHEAD_EN
  logic             byp_sel;
  logic [WIDTH-1:0] byp_data;

  // RAM continuously prefetches the next head; a write landing on that slot
  // in the same cycle is forwarded because the array reads old data.
  always_ff @(posedge clock) begin
    if (sclr) begin
      byp_sel <= 1'b0;
    end else begin
      byp_sel <= wr_acc && (wr_ptr == rd_nxt);
      if (wr_acc) byp_data <= data;
    end
  end

  always_comb begin
    ram_re     = 1'b1;
    ram_raddr  = rd_nxt[DEPTH_LOG2-1:0];
    q_zero_nxt = q_zero & (cm_nxt == rd_nxt);
    q          = q_zero ? '0 : (byp_sel ? byp_data : ram_q);
  end
`else
  always_comb begin
    ram_re     = rd_acc;
    ram_raddr  = rd_ptr[DEPTH_LOG2-1:0];
    q_zero_nxt = q_zero & ~rd_acc;
    q          = q_zero ? '0 : ram_q;
  end
`endif

  assign rdempty     = flags_q.rdempty;
  assign full        = flags_q.full;
  assign almost_full = flags_q.almost_full;
  assign drop        = flags_q.drop;
  assign underflow   = flags_q.underflow;
  assign usedw       = usedw_q;
  assign rdusedw     = rdusedw_q;

endmodule
